hilo_muldiv: RTL
================

// Module: hilo_muldiv
// PURPOSE
//  Multi-cycle MULT/MULTU/DIV/DIVU execution unit that sits directly upstream of the HI/LO register file.
//  Accepts one operation from EX and holds the pipeline via busy.
//  On completion, pulses done with a 64-bit result and a 2-bit HI/LO write enable that feeds the HI/LO write port.
//  Multiply is single-pass; divide is radix-2 restoring, one quotient bit per cycle.
// PARAMETERS
//  DATA_W   32  operand / HI / LO width (equals Data_Bus)
//  CNT_W    5   iteration counter width, = clog2(DATA_W)
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       asynchronous, active-low reset
//  start       in   1       launch op; accepted only when busy==0
//  op          in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//  src_a       in   DATA_W  rs operand / dividend; sampled with start
//  src_b       in   DATA_W  rt operand / divisor; sampled with start
//  flush       in   1       synchronous cancel of the in-flight op (exception / eret)
//  busy        out  1       op in flight; EX must stall while high
//  done        out  1       one-cycle pulse; result valid this cycle
//  whilo_o     out  2       {hi_we, lo_we}; equals {done,done}
//  data_o_hi   out  DATA_W  MUL: product[63:32]; DIV: remainder
//  data_o_lo   out  DATA_W  MUL: product[31:0];  DIV: quotient
// BEHAVIOUR
//  - Reset (rst==0, async): state=IDLE, busy=0, done=0, whilo_o=0, data_o_hi=data_o_lo=0, counter=0.
//  - States: IDLE, MUL, DIV, FIX, DONE. busy=1 in MUL/DIV/FIX, else 0. done=1 only in DONE.
//  - IDLE/DONE + start & !flush:
//    - op[1]==0 -> MUL.
//    - op[1]==1 & src_b!=0 -> DIV.
//    - op[1]==1 & src_b==0 -> FIX.
//    - Operands are latched.
//  - DONE without start -> IDLE. Start is ignored while busy==1.
//  - MUL (1 cycle): 64-bit product.
//    - Signed (op=00): sign-extend both operands to 64 bits.
//    - Unsigned (op=01): zero-extend both operands.
//    - Product registered into the result regs; -> DONE.
//    - Latency: start sampled at edge t, done high in the cycle after edge t+2.
//  - DIV: operate on magnitudes |a|, |b| (for DIVU, magnitude = raw value).
//    - Restoring division, MSB first; counter runs DATA_W-1 down to 0; one bit per cycle; DATA_W cycles.
//    - After the last bit -> FIX.
//  - FIX (1 cycle): sign correction, then -> DONE.
//    - Signed: quotient negated if a[31]^b[31]; remainder negated if a[31].
//    - Divide latency: done in the cycle after edge t+DATA_W+2, i.e. 34 cycles for DATA_W=32.
//  - Divide by zero: skip DIV and go straight to FIX.
//    - Result fixed as lo=all-ones, hi=src_a (no sign fix).
//    - done arrives in the cycle after edge t+2.
//  - Overflow case 0x8000_0000 / 0xFFFF_FFFF (signed): lo=0x8000_0000, hi=0. No trap.
//  - data_o_hi/lo are registered and hold the last result until the next done. Valid to consumers only while done==1.
//  - flush=1 in any state: -> IDLE at the next edge; done is not raised; result regs are unchanged.
//    - flush has priority over start in the same cycle.
//  - whilo_o is exactly {done,done}: never a partial write. HI/LO sees at most one write per op.
// TESTING
//  - Reset: assert rst low mid-DIV (cycle 10) -> busy=0, done=0, outputs 0 immediately; no done afterwards.
//  - MULT 0xFFFF_FFFE x 0x0000_0003 -> after 2 cycles done=1, whilo_o=11, hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
//    - Same operands with MULTU -> hi=0x0000_0002, lo=0xFFFF_FFFA.
//  - DIV -7 / 2 -> busy high 33 cycles, done at cycle 34, lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
//    - DIVU 100/7 -> lo=14, hi=2.
//  - DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
//    - DIVU 5/0 -> done after 2 cycles, lo=0xFFFF_FFFF, hi=5.
//  - flush at DIV cycle 15 with start=1 same cycle -> IDLE next cycle, no done, whilo_o stays 00.
//    - A new start afterwards completes normally.
//  - Back-to-back: start asserted in the DONE cycle -> new op accepted, busy=1 next cycle.
//    - start pulses during busy are ignored (no extra done).

Source files
------------

// File: rtl/hilo_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : hilo_muldiv
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU unit feeding the HI/LO register
//            file. Multiply finishes in one busy cycle. Divide is radix-2
//            restoring (one quotient bit per cycle) followed by one sign-fix
//            cycle. Divide by zero skips the iterations entirely.
// Ports    : clk        - clock, all state updates on posedge
//            rst        - asynchronous active-low reset
//            start      - launch op, accepted only while busy==0
//            op         - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//            src_a/src_b- rs/rt operands (dividend/divisor)
//            flush      - cancel the in-flight op, back to IDLE next edge
//            busy       - op in flight (MUL/DIV/FIX)
//            done       - one-cycle result-valid pulse
//            whilo_o    - {hi_we, lo_we} == {done, done}
//            data_o_hi  - product[63:32] or remainder
//            data_o_lo  - product[31:0] or quotient
// Revision : 1.0 - initial release
// ============================================================================
module hilo_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [1:0]        whilo_o,
  output logic [DATA_W-1:0] data_o_hi,
  output logic [DATA_W-1:0] data_o_lo
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   a_reg;      // raw rs, kept for multiply and div-by-zero HI
  logic [DATA_W-1:0]   b_reg;      // raw rt, used by multiply
  logic                mul_signed;
  logic                div_zero;
  logic                neg_q;
  logic                neg_r;
  logic [DATA_W-1:0]   quo;        // holds |a| initially, shifts quotient bits in
  logic [DATA_W-1:0]   rem;
  logic [DATA_W-1:0]   dvs;        // |b|
  logic [CNT_W-1:0]    cnt;

  // Operand magnitudes at launch; signed only applies to DIV (op[0]==0).
  logic                signed_div;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  assign signed_div = ~op[0];
  assign mag_a = (signed_div && src_a[DATA_W-1]) ? -src_a : src_a;
  assign mag_b = (signed_div && src_b[DATA_W-1]) ? -src_b : src_b;

  // Single-pass multiply on extended operands.
  logic [2*DATA_W-1:0] ext_a;
  logic [2*DATA_W-1:0] ext_b;
  logic [2*DATA_W-1:0] product;
  assign ext_a   = mul_signed ? {{DATA_W{a_reg[DATA_W-1]}}, a_reg} : {{DATA_W{1'b0}}, a_reg};
  assign ext_b   = mul_signed ? {{DATA_W{b_reg[DATA_W-1]}}, b_reg} : {{DATA_W{1'b0}}, b_reg};
  assign product = ext_a * ext_b;

  // One restoring step: shift next dividend bit into the partial remainder and
  // trial-subtract the divisor. The extra top bit catches the shifted-out MSB.
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     diff;
  assign rem_sh = {rem, quo[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, dvs};

  assign whilo_o = {done, done};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_o_hi  <= '0;
      data_o_lo  <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      mul_signed <= 1'b0;
      div_zero   <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      dvs        <= '0;
      cnt        <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        // Cancel wins over start; result registers keep their old contents.
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              a_reg      <= src_a;
              b_reg      <= src_b;
              mul_signed <= ~op[0];
              div_zero   <= (src_b == '0);
              neg_q      <= signed_div && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
              neg_r      <= signed_div && src_a[DATA_W-1];
              quo        <= mag_a;
              rem        <= '0;
              dvs        <= mag_b;
              cnt        <= CNT_W'(DATA_W - 1);
              busy       <= 1'b1;
              if (!op[1])               state <= S_MUL;
              else if (src_b != '0)     state <= S_DIV;
              else                      state <= S_FIX;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end
          S_MUL: begin
            data_o_hi <= product[2*DATA_W-1:DATA_W];
            data_o_lo <= product[DATA_W-1:0];
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
          S_DIV: begin
            if (!diff[DATA_W]) begin
              rem <= diff[DATA_W-1:0];
              quo <= {quo[DATA_W-2:0], 1'b1};
            end else begin
              rem <= rem_sh[DATA_W-1:0];
              quo <= {quo[DATA_W-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= S_FIX;
          end
          S_FIX: begin
            if (div_zero) begin
              data_o_lo <= '1;
              data_o_hi <= a_reg;
            end else begin
              data_o_lo <= neg_q ? -quo : quo;
              data_o_hi <= neg_r ? -rem : rem;
            end
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
